// File: rtl/hd44780_pkg.sv
// Shared types and command constants for the HD44780 4-bit nibble driver.
// The init table below is the power-up sequence that puts the LCD into 4-bit, 2-line mode.
package hd44780_pkg;

  localparam logic [7:0] CMD_FUNC_4BIT_2L = 8'h28;
  localparam logic [7:0] CMD_DISP_ON      = 8'h0C;
  localparam logic [7:0] CMD_CLEAR        = 8'h01;
  localparam logic [7:0] CMD_HOME         = 8'h02;
  localparam logic [7:0] CMD_ENTRY_INC    = 8'h06;

  localparam logic [2:0] INIT_LAST_STEP = 3'd7;

  typedef enum logic [2:0] {
    POWERUP,
    INIT,
    IDLE,
    NIB_SETUP,
    NIB_PULSE,
    NIB_HOLD,
    WAIT
  } state_t;

  typedef struct packed {
    logic        nibble_only;
    logic [7:0]  cmd_byte;
    logic [15:0] wait_us;
  } init_step_t;

  // Nibble-only steps carry their nibble in the high half of cmd_byte.
  function automatic init_step_t init_step(input logic [2:0]  idx,
                                           input logic [15:0] short_us,
                                           input logic [15:0] long_us);
    init_step_t s;
    case (idx)
      3'd0:    s = '{1'b1, 8'h30, 16'd5000};
      3'd1:    s = '{1'b1, 8'h30, 16'd200};
      3'd2:    s = '{1'b1, 8'h30, 16'd200};
      3'd3:    s = '{1'b1, 8'h20, 16'd200};
      3'd4:    s = '{1'b0, CMD_FUNC_4BIT_2L, short_us};
      3'd5:    s = '{1'b0, CMD_DISP_ON, short_us};
      3'd6:    s = '{1'b0, CMD_CLEAR, long_us};
      default: s = '{1'b0, CMD_ENTRY_INC, short_us};
    endcase
    return s;
  endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Down-counter used for every timed phase; done is high while the count sits at 1.
// A state that loads N therefore lasts exactly N cycles.
module lcd_delay_timer #(
  parameter int             W         = 16,
  parameter logic [W-1:0]   RESET_VAL = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= RESET_VAL;
    end else if (load) begin
      count <= value;
    end else if (count > W'(1)) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == W'(1));

endmodule

// File: rtl/hd44780_nibble_driver.sv
// HD44780 4-bit bus driver: power-up init, then one byte command per accepted
// writeChar/home request, paced back to the line writer through ready.
//
// state     | meaning
// POWERUP   | waiting for LCD supply to settle after reset
// INIT      | fetch the next init-table step
// IDLE      | ready=1, waiting for writeChar/home
// NIB_SETUP | rs/data driven, E low
// NIB_PULSE | E high
// NIB_HOLD  | E low, rs/data held
// WAIT      | command execution time
module hd44780_nibble_driver
  import hd44780_pkg::*;
#(
  parameter int CLK_HZ        = 12000000,
  parameter int POWERUP_US    = 20000,
  parameter int SHORT_WAIT_US = 50,
  parameter int LONG_WAIT_US  = 2000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] char,
  input  logic       writeChar,
  input  logic       home,
  output logic       ready,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [3:0] lcd_data
);

  localparam int CYC_US = CLK_HZ / 1000000;
  localparam int MAX_US = (POWERUP_US > 5000)
                          ? ((POWERUP_US > LONG_WAIT_US) ? POWERUP_US : LONG_WAIT_US)
                          : ((LONG_WAIT_US > 5000) ? LONG_WAIT_US : 5000);
  localparam int TW = $clog2(MAX_US * CYC_US + 1);

  localparam logic [TW-1:0] CYC_TW   = TW'(CYC_US);
  localparam logic [TW-1:0] ONE_TW   = TW'(1);
  localparam logic [TW-1:0] PWR_TW   = TW'(POWERUP_US * CYC_US);
  localparam logic [TW-1:0] SHORT_TW = TW'(SHORT_WAIT_US * CYC_US);
  localparam logic [TW-1:0] LONG_TW  = TW'(LONG_WAIT_US * CYC_US);

  if (CYC_US < 1) begin : g_bad_clk
    $error("hd44780_nibble_driver: CLK_HZ must be at least 1 MHz");
  end

  state_t        state;
  logic [2:0]    step;
  logic [7:0]    cur_byte;
  logic          low_phase;
  logic          nib_only;
  logic          in_init;
  logic [TW-1:0] wait_cyc;

  init_step_t    cur_step;
  logic [TW-1:0] step_wait;
  logic          accept;
  logic          last_nibble;
  logic          tmr_load;
  logic [TW-1:0] tmr_value;
  logic          tmr_done;

  assign cur_step    = init_step(step, 16'(SHORT_WAIT_US), 16'(LONG_WAIT_US));
  assign step_wait   = TW'(32'(cur_step.wait_us) * CYC_US);
  assign accept      = (state == IDLE) && (writeChar || home);
  assign last_nibble = nib_only || low_phase;
  assign lcd_rw      = 1'b0;

  // The timer is reloaded on the same edge the FSM changes state, with the
  // length of the state being entered.
  always_comb begin
    tmr_load  = (state == IDLE) ? accept : tmr_done;
    tmr_value = CYC_TW;
    if (state == POWERUP || state == WAIT) begin
      tmr_value = ONE_TW;
    end else if (state == NIB_HOLD && last_nibble) begin
      tmr_value = wait_cyc;
    end
  end

  lcd_delay_timer #(
    .W         (TW),
    .RESET_VAL (PWR_TW)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (tmr_load),
    .value (tmr_value),
    .done  (tmr_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= POWERUP;
      step      <= 3'd0;
      cur_byte  <= 8'h00;
      low_phase <= 1'b0;
      nib_only  <= 1'b0;
      in_init   <= 1'b1;
      wait_cyc  <= ONE_TW;
      ready     <= 1'b0;
      lcd_e     <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_data  <= 4'h0;
    end else begin
      case (state)
        POWERUP: if (tmr_done) begin
          state   <= INIT;
          step    <= 3'd0;
          in_init <= 1'b1;
        end
        INIT: if (tmr_done) begin
          cur_byte  <= cur_step.cmd_byte;
          nib_only  <= cur_step.nibble_only;
          wait_cyc  <= step_wait;
          low_phase <= 1'b0;
          lcd_rs    <= 1'b0;
          lcd_data  <= cur_step.cmd_byte[7:4];
          state     <= NIB_SETUP;
        end
        IDLE: if (accept) begin
          ready     <= 1'b0;
          in_init   <= 1'b0;
          nib_only  <= 1'b0;
          low_phase <= 1'b0;
          state     <= NIB_SETUP;
          // home takes priority; a simultaneous character is dropped
          if (home) begin
            cur_byte <= CMD_HOME;
            lcd_rs   <= 1'b0;
            lcd_data <= CMD_HOME[7:4];
            wait_cyc <= LONG_TW;
          end else begin
            cur_byte <= char;
            lcd_rs   <= 1'b1;
            lcd_data <= char[7:4];
            wait_cyc <= SHORT_TW;
          end
        end
        NIB_SETUP: if (tmr_done) begin
          lcd_e <= 1'b1;
          state <= NIB_PULSE;
        end
        NIB_PULSE: if (tmr_done) begin
          lcd_e <= 1'b0;
          state <= NIB_HOLD;
        end
        NIB_HOLD: if (tmr_done) begin
          if (!last_nibble) begin
            low_phase <= 1'b1;
            lcd_data  <= cur_byte[3:0];
            state     <= NIB_SETUP;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: if (tmr_done) begin
          if (in_init && step != INIT_LAST_STEP) begin
            step  <= step + 3'd1;
            state <= INIT;
          end else begin
            in_init <= 1'b0;
            ready   <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= POWERUP;
      endcase
    end
  end

endmodule

// File: tb/tb_hd44780_nibble_driver.sv
// Scoreboard bench: every request pushes the nibbles it should produce; a monitor
// pops one entry per rising lcd_e and compares rs/data.
module tb_hd44780_nibble_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] char = 8'h00;
  logic       writeChar = 1'b0;
  logic       home = 1'b0;
  logic       ready, lcd_rs, lcd_rw, lcd_e;
  logic [3:0] lcd_data;

  int n_chk = 0;
  int n_err = 0;
  int cyc_total = 0;
  int last_rise_cyc = 0;
  int n_pulses = 0;
  int n_pushed = 0;
  logic [4:0] exp_q[$];

  hd44780_nibble_driver #(
    .CLK_HZ        (1000000),
    .POWERUP_US    (100),
    .SHORT_WAIT_US (50),
    .LONG_WAIT_US  (2000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .char      (char),
    .writeChar (writeChar),
    .home      (home),
    .ready     (ready),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_e     (lcd_e),
    .lcd_data  (lcd_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_total <= cyc_total + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic rs, input logic [3:0] nib);
    exp_q.push_back({rs, nib});
    n_pushed++;
  endtask

  initial begin : monitor
    logic prev_e;
    logic [4:0] e;
    prev_e = 1'b0;
    forever begin
      @(negedge clk);
      if (lcd_e && !prev_e) begin
        n_pulses++;
        last_rise_cyc = cyc_total;
        chk("rw_low", lcd_rw, 1'b0);
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          chk("nibble", {lcd_rs, lcd_data}, e);
        end
      end
      prev_e = lcd_e;
    end
  end

  task automatic wait_ready(input int budget);
    int n;
    n = 0;
    while (!ready && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!ready) chk("ready_timeout", ready, 1'b1);
  endtask

  task automatic send(input logic wc, input logic hm, input logic [7:0] ch, output int acc);
    wait_ready(3000);
    writeChar = wc;
    home      = hm;
    char      = ch;
    acc       = cyc_total + 1;
    if (hm) begin
      push(1'b0, 4'h0);
      push(1'b0, 4'h2);
    end else begin
      push(1'b1, ch[7:4]);
      push(1'b1, ch[3:0]);
    end
    @(negedge clk);
    chk("ready_drop", ready, 1'b0);
    writeChar = 1'b0;
    home      = 1'b0;
  endtask

  task automatic run_init();
    int base;
    int n;
    logic [3:0] init_nibs [12] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8,
                                   4'h0, 4'hC, 4'h0, 4'h1, 4'h0, 4'h6};
    foreach (init_nibs[i]) push(1'b0, init_nibs[i]);
    @(negedge clk);
    rst_n = 1'b1;
    base  = cyc_total;
    #1 chk("ready_after_release", ready, 1'b0);
    n = 0;
    while (!lcd_e && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("first_e_seen", lcd_e, 1'b1);
    chk("first_e_cycle", cyc_total - base - 1, 101);
    wait_ready(20000);
    chk("init_ready_gap", cyc_total - last_rise_cyc, 52);
    chk("init_queue_empty", exp_q.size(), 0);
  endtask

  task automatic cmd_len(input logic wc, input logic hm, input logic [7:0] ch,
                         input int len, input string tag);
    int acc;
    send(wc, hm, ch, acc);
    wait_ready(3000);
    chk(tag, cyc_total - acc, len);
    chk({tag, "_queue"}, exp_q.size(), 0);
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int acc;
    int n;
    string line;
    line = "AAAABBBBCCCCABCD";
    #23;
    chk("rst_ready", ready, 1'b0);
    chk("rst_e", lcd_e, 1'b0);
    chk("rst_rs", lcd_rs, 1'b0);
    chk("rst_rw", lcd_rw, 1'b0);
    chk("rst_data", lcd_data, 4'h0);
    run_init();

    cmd_len(1'b1, 1'b0, 8'h41, 56, "char_41_len");
    cmd_len(1'b0, 1'b1, 8'h00, 2006, "home_len");
    cmd_len(1'b1, 1'b1, 8'h5A, 2006, "both_len");
    cmd_len(1'b1, 1'b0, 8'h00, 56, "char_00_len");

    for (int i = 0; i < 16; i++) send(1'b1, 1'b0, line[i], acc);
    send(1'b0, 1'b1, 8'h00, acc);
    wait_ready(3000);
    chk("line_queue_empty", exp_q.size(), 0);

    // Reset in the middle of the first E pulse of a character.
    send(1'b1, 1'b0, 8'h55, acc);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!lcd_e && n < 20);
    chk("pulse_before_reset", lcd_e, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_drops_e", lcd_e, 1'b0);
    chk("reset_drops_ready", ready, 1'b0);
    n_pushed -= exp_q.size();
    exp_q.delete();
    repeat (3) @(negedge clk);
    run_init();
    cmd_len(1'b1, 1'b0, 8'h42, 56, "char_after_reset");

    repeat (10) @(negedge clk);
    chk("pulse_count", n_pulses, n_pushed);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/hd44780_nibble_driver.md
Name: hd44780_nibble_driver

Overview:
- Downstream consumer of the LCD line writer's `char`/`writeChar`/`home` strobes.
- Runs the HD44780 4-bit-mode power-up initialisation, then turns each accepted character or home request into two timed nibble writes on the LCD bus.
- Drives `ready` back to the line writer so it paces one request per completed LCD command.

Parameters:
- CLK_HZ, 12000000, clk frequency. CYC_US = CLK_HZ/1000000 must be ≥1; checked at elaboration.
- POWERUP_US, 20000, wait after reset before the first init nibble.
- SHORT_WAIT_US, 50, execution wait after data writes and ordinary commands.
- LONG_WAIT_US, 2000, execution wait after clear (0x01) and home (0x02).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- char  in  8  character code to display
- writeChar  in  1  request: write `char` as data (RS=1)
- home  in  1  request: return-home command 0x02 (RS=0)
- ready  out  1  high = idle and able to accept a request
- lcd_rs  out  1  register select
- lcd_rw  out  1  constant 0 (write only)
- lcd_e  out  1  enable strobe
- lcd_data  out  4  DB7..DB4

Behaviour:
- Reset (async, rst_n=0): ready=0, lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_data=0, state=POWERUP, timer loaded with POWERUP_US*CYC_US. A reset mid-command drops lcd_e in the same instant and restarts the full init sequence.
- States: POWERUP, INIT, IDLE, NIB_SETUP, NIB_PULSE, NIB_HOLD, WAIT.
- POWERUP: count down, then go to INIT with step=0.
- INIT steps, in order (nibble-only steps send a single nibble):
  - 0: nibble 0x3, wait 5000 us
  - 1: nibble 0x3, wait 200 us
  - 2: nibble 0x3, wait 200 us
  - 3: nibble 0x2, wait 200 us
  - 4: byte 0x28, short wait
  - 5: byte 0x0C, short wait
  - 6: byte 0x01, long wait
  - 7: byte 0x06, short wait
  - After step 7 completes: IDLE.
- All init steps use RS=0.
- Nibble timing: each of NIB_SETUP, NIB_PULSE and NIB_HOLD lasts exactly CYC_US cycles.
  - lcd_rs and lcd_data are driven on entry to SETUP and held through HOLD.
  - lcd_e=1 only in PULSE.
- Byte sequencing: high nibble first. After the high nibble's HOLD, go straight to SETUP for the low nibble. After the last HOLD, go to WAIT for the step's wait time × CYC_US cycles.
- IDLE: ready=1.
  - Acceptance happens on a rising edge where ready=1 and (writeChar|home).
  - On that same edge: latch byte and RS, set ready<=0, enter NIB_SETUP with the high nibble.
  - writeChar latches (char, RS=1, short wait). home latches (0x02, RS=0, long wait).
- Simultaneous writeChar and home: home wins and the character is discarded, not queued.
- Requests while ready=0 are ignored and never buffered. The upstream holds its strobe until it sees ready=0, and ready stays low for the whole command (≥ 6*CYC_US+1 cycles), so a held strobe cannot be double-accepted.
- Ready return: ready<=1 on the edge WAIT completes. Char command length from the acceptance edge = 6*CYC_US + SHORT_WAIT_US*CYC_US cycles.
- char 0x00 is written as-is; no substitution here.
- Timer: a single down-counter, width $clog2(max(POWERUP_US,5000,LONG_WAIT_US)*CYC_US+1). It is loaded on each state entry, and the state advances when it reaches 1. Zero-length loads are not permitted; minimum load is 1.

Decomposition:
- hd44780_pkg holds:
  - command constants: CMD_FUNC_4BIT_2L=0x28, CMD_DISP_ON=0x0C, CMD_CLEAR=0x01, CMD_HOME=0x02, CMD_ENTRY_INC=0x06
  - state enum
  - init-step record (nibble_only, byte, wait_us) plus the 8-entry init table
- One sub-module, lcd_delay_timer (load, value, done), is instantiated once.

Test Plan (CLK_HZ=1000000, POWERUP_US=100):
- Reset release → ready=0. First lcd_e rise at cycle 101 with lcd_data=0x3, rs=0. Nibble sequence 3,3,3,2,2,8,0,C,0,1,0,6 observed. ready=1 only after the 0x06 step's 50-cycle wait.
- In IDLE, char=0x41 with writeChar held until ready=0 → ready falls on the next edge. Two E pulses with rs=1, data 0x4 then 0x1. ready rises exactly 56 cycles after acceptance. Exactly one write occurs.
- home pulse → rs=0, nibbles 0x0 then 0x2; ready returns after 6+2000 cycles.
- writeChar and home asserted on the same edge → only 0x02 is sent; no RS=1 pulse appears.
- The line writer instantiated upstream with 16 chars "AAAABBBBCCCCABCD" → 16 data bytes in order, then one home; repeats indefinitely.
- rst_n asserted during NIB_PULSE → lcd_e=0 and ready=0 immediately. After release, the full init sequence reruns from POWERUP.
